// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mdu_ctrl
// Brief   : E-stage multiply/divide sequencer with HI/LO registers and a
//           fixed-latency busy countdown that drives the D-stage stall.
// Revision: 1.0 - initial release
// ============================================================================
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    input  logic        md_use,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int C_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int C_CNT_W      = $clog2(C_MAX_CYCLES + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]         r_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_res_hi;
    logic [31:0]        r_res_lo;
    logic               r_res_wr;

    logic               w_signed;
    logic               w_div0;
    logic [63:0]        w_prod;
    logic [31:0]        w_dvd;
    logic [31:0]        w_dvs;
    logic [31:0]        w_qmag;
    logic [31:0]        w_rmag;
    logic [31:0]        w_quot;
    logic [31:0]        w_rem;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;
    logic [C_CNT_W-1:0] w_load;

    // Signed divide works on magnitudes, so 0x80000000 / -1 falls out as
    // 0x80000000 with no overflow special case.
    always_comb begin
        w_signed = ~op[0];
        w_div0   = (b == 32'd0);
        if (w_signed)
            w_prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        else
            w_prod = {32'd0, a} * {32'd0, b};
        w_dvd  = (w_signed && a[31]) ? (32'd0 - a) : a;
        w_dvs  = (w_signed && b[31]) ? (32'd0 - b) : b;
        if (w_div0)
            w_dvs = 32'd1;
        w_qmag = w_dvd / w_dvs;
        w_rmag = w_dvd % w_dvs;
        w_quot = (w_signed && (a[31] ^ b[31])) ? (32'd0 - w_qmag) : w_qmag;
        w_rem  = (w_signed && a[31]) ? (32'd0 - w_rmag) : w_rmag;
        if (op[1]) begin
            w_res_hi = w_rem;
            w_res_lo = w_quot;
            w_load   = C_CNT_W'(DIV_CYCLES);
        end else begin
            w_res_hi = w_prod[63:32];
            w_res_lo = w_prod[31:0];
            w_load   = C_CNT_W'(MULT_CYCLES);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
            r_res_wr <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (start) begin
                r_res_hi <= w_res_hi;
                r_res_lo <= w_res_lo;
                r_res_wr <= ~(op[1] & w_div0);
                r_cnt    <= w_load;
                r_state  <= ST_BUSY;
            end else begin
                if (hi_we)
                    r_hi <= wdata;
                if (lo_we)
                    r_lo <= wdata;
            end
        end else begin
            r_cnt <= r_cnt - C_CNT_W'(1);
            if (r_cnt == C_CNT_W'(1)) begin
                // A divide by zero keeps its timing but leaves HI/LO alone.
                if (r_res_wr) begin
                    r_hi <= r_res_hi;
                    r_lo <= r_res_lo;
                end
                r_state <= ST_IDLE;
            end
        end
    end

    assign busy      = (r_state == ST_BUSY);
    assign stall_req = md_use & (busy | start);
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mdu_ctrl
// Brief   : Directed self-checking bench for mdu_ctrl with hand-computed vectors.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        md_use;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int vec_cnt;
    int err_cnt;
    int n_busy;
    int n_stall;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wdata     (wdata),
        .md_use    (md_use),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one operation at a negedge, then counts busy and stall cycles
    // (the stall count includes the start cycle) until busy drops.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic mtlo, output int nb, output int ns);
        nb = 0;
        ns = 0;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; lo_we = mtlo; wdata = 32'hDEAD_BEEF;
        #1 ns += int'(stall_req);
        @(negedge clk);
        start = 1'b0; lo_we = 1'b0;
        #1;
        while (busy && nb < 50) begin
            nb++;
            ns += int'(stall_req);
            @(negedge clk);
            #1;
        end
        if (nb >= 50)
            chk("busy_timeout", 32'(busy), 32'd0);
    endtask

    task automatic mt(input logic h, input logic l, input logic [31:0] d);
        @(negedge clk);
        hi_we = h; lo_we = l; wdata = d;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        #1;
    endtask

    initial begin
        vec_cnt = 0; err_cnt = 0;
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0; md_use = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        md_use = 1'b0;

        run_op(OP_MULT, 32'd3, 32'hFFFF_FFFE, 1'b0, n_busy, n_stall);
        chk("mult1_cycles", 32'(n_busy), 32'd5);
        chk("mult1_hi", hi, 32'hFFFF_FFFF);
        chk("mult1_lo", lo, 32'hFFFF_FFFA);
        chk("nouse_stall", 32'(n_stall), 32'd0);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, n_busy, n_stall);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);
        run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, n_busy, n_stall);
        chk("mult2_hi", hi, 32'hFFFF_FFFF);
        chk("mult2_lo", lo, 32'hFFFF_FFFE);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, n_busy, n_stall);
        chk("div_cycles", 32'(n_busy), 32'd10);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        run_op(OP_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b0, n_busy, n_stall);
        chk("divu_lo", lo, 32'h7FFF_FFFC);
        chk("divu_hi", hi, 32'h0000_0001);

        mt(1'b1, 1'b0, 32'h0000_1234);
        chk("mthi_hi", hi, 32'h0000_1234);
        chk("mthi_lo", lo, 32'h7FFF_FFFC);
        run_op(OP_DIV, 32'd77, 32'd0, 1'b0, n_busy, n_stall);
        chk("div0_cycles", 32'(n_busy), 32'd10);
        chk("div0_hi", hi, 32'h0000_1234);
        chk("div0_lo", lo, 32'h7FFF_FFFC);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, n_busy, n_stall);
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'h0000_0000);

        mt(1'b1, 1'b1, 32'h0000_0055);
        chk("mtboth_hi", hi, 32'h0000_0055);
        chk("mtboth_lo", lo, 32'h0000_0055);

        md_use = 1'b1;
        run_op(OP_DIV, 32'd100, 32'd7, 1'b0, n_busy, n_stall);
        chk("stall_cycles", 32'(n_stall), 32'd11);
        chk("stall_after", 32'(stall_req), 32'd0);
        chk("div7_lo", lo, 32'd14);
        chk("div7_hi", hi, 32'd2);
        md_use = 1'b0;

        // start with mtlo: lo must stay untouched until the product lands.
        @(negedge clk);
        start = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd7; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; lo_we = 1'b0;
        #1 chk("mtlo_drop_mid", lo, 32'd14);
        n_busy = 0;
        while (busy && n_busy < 50) begin
            n_busy++;
            @(negedge clk);
            #1;
        end
        chk("mtlo_drop_lo", lo, 32'd35);
        chk("mtlo_drop_hi", hi, 32'd0);

        // async reset at busy cycle 3 of a mult
        @(negedge clk);
        start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        chk("arst_late_busy", 32'(busy), 32'd0);
        chk("arst_late_lo", lo, 32'd0);
        run_op(OP_MULT, 32'd3, 32'hFFFF_FFFE, 1'b0, n_busy, n_stall);
        chk("arst_new_cycles", 32'(n_busy), 32'd5);
        chk("arst_new_lo", lo, 32'hFFFF_FFFA);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
